// File: rtl/biu_icb_arbiter_pkg.sv
// Shared constants for the BIU ICB arbiter: master IDs and default outstanding depth.
package biu_icb_arbiter_pkg;

  localparam logic ID_ICACHE = 1'b0;
  localparam logic ID_DCACHE = 1'b1;

  localparam int OST_DEPTH_DEF = 4;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/biu_icb_arbiter_id_fifo.sv
// In-order 1-bit ID FIFO recording which master owns each outstanding memory transaction.
// Wrap-bit pointers; push is ignored when full and pop is ignored when empty.
module biu_id_fifo
  import biu_icb_arbiter_pkg::*;
#(
  parameter int DEPTH = OST_DEPTH_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_w(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [DEPTH-1:0] mem_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/biu_icb_arbiter.sv
// Two-master (I-cache / D-cache) ICB arbiter onto the BIU memory port, zero added latency.
// BIU_RR_ARB_EN selects round-robin arbitration; otherwise the D-cache has fixed priority.
module biu_icb_arbiter
  import biu_icb_arbiter_pkg::*;
#(
  parameter int ADW       = 64,
  parameter int DW        = 64,
  parameter int OST_DEPTH = OST_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rstn,

  input  logic           icache2icb_cmd_valid,
  output logic           icache2icb_cmd_ready,
  input  logic [ADW-1:0] icache2icb_cmd_addr,
  output logic           icache2icb_rsp_valid,
  output logic [DW-1:0]  icache2icb_rsp_rdata,
  output logic           icache2icb_rsp_err,

  input  logic           dcache2icb_cmd_valid,
  output logic           dcache2icb_cmd_ready,
  input  logic [ADW-1:0] dcache2icb_cmd_addr,
  input  logic           dcache2icb_cmd_read,
  input  logic [DW-1:0]  dcache2icb_cmd_wdata,
  input  logic [7:0]     dcache2icb_cmd_wmask,
  output logic           dcache2icb_rsp_valid,
  output logic [DW-1:0]  dcache2icb_rsp_rdata,
  output logic           dcache2icb_rsp_err,

  output logic           biu2mem_cmd_valid,
  input  logic           biu2mem_cmd_ready,
  output logic [ADW-1:0] biu2mem_cmd_addr,
  output logic           biu2mem_cmd_read,
  output logic [DW-1:0]  biu2mem_cmd_wdata,
  output logic [7:0]     biu2mem_cmd_wmask,
  input  logic           biu2mem_rsp_valid,
  output logic           biu2mem_rsp_ready,
  input  logic [DW-1:0]  biu2mem_rsp_rdata,
  input  logic           biu2mem_rsp_err
);

  logic fifo_full, fifo_empty, fifo_head;
  logic i_elig, d_elig, both_pick;
  logic grant_id;
  logic cmd_hs, rsp_hs;
  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;

`ifdef BIU_RR_ARB_EN
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (cmd_hs) rr_d = ~grant_id;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_q <= ID_DCACHE;
    else       rr_q <= rr_d;
  end

  assign both_pick = rr_q;
`else
  assign both_pick = ID_DCACHE;
`endif

  assign i_elig = icache2icb_cmd_valid && !fifo_full;
  assign d_elig = dcache2icb_cmd_valid && !fifo_full;

  always_comb begin
    if (lock_q)               grant_id = lock_id_q;
    else if (i_elig && d_elig) grant_id = both_pick;
    else if (d_elig)          grant_id = ID_DCACHE;
    else                      grant_id = ID_ICACHE;
  end

  assign biu2mem_cmd_valid = ((grant_id == ID_DCACHE) ? dcache2icb_cmd_valid
                                                      : icache2icb_cmd_valid) && !fifo_full;
  assign cmd_hs = biu2mem_cmd_valid && biu2mem_cmd_ready;

  assign icache2icb_cmd_ready = (grant_id == ID_ICACHE) && biu2mem_cmd_ready && !fifo_full;
  assign dcache2icb_cmd_ready = (grant_id == ID_DCACHE) && biu2mem_cmd_ready && !fifo_full;

  // I-cache traffic is always a full read with no write payload.
  always_comb begin
    if (grant_id == ID_DCACHE) begin
      biu2mem_cmd_addr  = dcache2icb_cmd_addr;
      biu2mem_cmd_read  = dcache2icb_cmd_read;
      biu2mem_cmd_wdata = dcache2icb_cmd_wdata;
      biu2mem_cmd_wmask = dcache2icb_cmd_wmask;
    end else begin
      biu2mem_cmd_addr  = icache2icb_cmd_addr;
      biu2mem_cmd_read  = 1'b1;
      biu2mem_cmd_wdata = '0;
      biu2mem_cmd_wmask = '0;
    end
  end

  // Hold the grant while a presented command is stalled; a dropped valid also releases it.
  assign lock_d    = biu2mem_cmd_valid && !biu2mem_cmd_ready;
  assign lock_id_d = grant_id;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_ICACHE;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  assign biu2mem_rsp_ready = 1'b1;
  assign rsp_hs = biu2mem_rsp_valid && !fifo_empty;

  assign icache2icb_rsp_valid = rsp_hs && (fifo_head == ID_ICACHE);
  assign dcache2icb_rsp_valid = rsp_hs && (fifo_head == ID_DCACHE);
  assign icache2icb_rsp_rdata = biu2mem_rsp_rdata;
  assign dcache2icb_rsp_rdata = biu2mem_rsp_rdata;
  assign icache2icb_rsp_err   = icache2icb_rsp_valid && biu2mem_rsp_err;
  assign dcache2icb_rsp_err   = dcache2icb_rsp_valid && biu2mem_rsp_err;

  biu_id_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (cmd_hs),
    .din_i   (grant_id),
    .pop_i   (rsp_hs),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_biu_icb_arbiter.sv
// Scoreboard bench for biu_icb_arbiter: expected owner/data queued at command time, checked at response.
module tb_biu_icb_arbiter;
  import biu_icb_arbiter_pkg::*;

  logic        clk;
  logic        rstn;
  logic        ic_v, ic_rdy, ic_rsp_v, ic_err;
  logic [63:0] ic_addr, ic_rdata;
  logic        dc_v, dc_rdy, dc_read, dc_rsp_v, dc_err;
  logic [63:0] dc_addr, dc_wdata, dc_rdata;
  logic [7:0]  dc_wmask;
  logic        m_v, m_rdy, m_read, m_rsp_v, m_rsp_rdy, m_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wmask;

  typedef struct {
    logic        m;
    logic [63:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  biu_icb_arbiter dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .icache2icb_cmd_valid (ic_v),
    .icache2icb_cmd_ready (ic_rdy),
    .icache2icb_cmd_addr  (ic_addr),
    .icache2icb_rsp_valid (ic_rsp_v),
    .icache2icb_rsp_rdata (ic_rdata),
    .icache2icb_rsp_err   (ic_err),
    .dcache2icb_cmd_valid (dc_v),
    .dcache2icb_cmd_ready (dc_rdy),
    .dcache2icb_cmd_addr  (dc_addr),
    .dcache2icb_cmd_read  (dc_read),
    .dcache2icb_cmd_wdata (dc_wdata),
    .dcache2icb_cmd_wmask (dc_wmask),
    .dcache2icb_rsp_valid (dc_rsp_v),
    .dcache2icb_rsp_rdata (dc_rdata),
    .dcache2icb_rsp_err   (dc_err),
    .biu2mem_cmd_valid    (m_v),
    .biu2mem_cmd_ready    (m_rdy),
    .biu2mem_cmd_addr     (m_addr),
    .biu2mem_cmd_read     (m_read),
    .biu2mem_cmd_wdata    (m_wdata),
    .biu2mem_cmd_wmask    (m_wmask),
    .biu2mem_rsp_valid    (m_rsp_v),
    .biu2mem_rsp_ready    (m_rsp_rdy),
    .biu2mem_rsp_rdata    (m_rdata),
    .biu2mem_rsp_err      (m_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command cycle with memory ready; records which master must own the response.
  task automatic issue(input logic iv, input logic dv, input logic exp_m,
                       input logic [63:0] rd, input logic er);
    exp_t x;
    ic_v = iv;
    dc_v = dv;
    #2;
    chk("cmd_vld", 64'(m_v), 64'd1);
    chk("i_rdy", 64'(ic_rdy), 64'(exp_m == ID_ICACHE));
    chk("d_rdy", 64'(dc_rdy), 64'(exp_m == ID_DCACHE));
    chk("cmd_addr", m_addr, (exp_m == ID_DCACHE) ? dc_addr : ic_addr);
    chk("cmd_read", 64'(m_read), (exp_m == ID_DCACHE) ? 64'(dc_read) : 64'd1);
    chk("cmd_wmask", 64'(m_wmask), (exp_m == ID_DCACHE) ? 64'(dc_wmask) : 64'd0);
    x.m = exp_m;
    x.d = rd;
    x.e = er;
    exp_q.push_back(x);
    tick();
  endtask

  task automatic rsp_drive(input logic [63:0] stray);
    m_rsp_v = 1'b1;
    if (exp_q.size() > 0) begin
      m_rdata = exp_q[0].d;
      m_err   = exp_q[0].e;
    end else begin
      m_rdata = stray;
      m_err   = 1'b0;
    end
  endtask

  task automatic rsp_check();
    exp_t x;
    if (exp_q.size() == 0) begin
      chk("drop_i_vld", 64'(ic_rsp_v), 64'd0);
      chk("drop_d_vld", 64'(dc_rsp_v), 64'd0);
    end else begin
      x = exp_q.pop_front();
      chk("rsp_i_vld", 64'(ic_rsp_v), 64'(x.m == ID_ICACHE));
      chk("rsp_d_vld", 64'(dc_rsp_v), 64'(x.m == ID_DCACHE));
      chk("rsp_rdata", (x.m == ID_DCACHE) ? dc_rdata : ic_rdata, x.d);
      chk("rsp_err", (x.m == ID_DCACHE) ? 64'(dc_err) : 64'(ic_err), 64'(x.e));
    end
  endtask

  task automatic do_rsp(input logic [63:0] stray);
    rsp_drive(stray);
    #2;
    rsp_check();
    tick();
    m_rsp_v = 1'b0;
  endtask

  initial begin
    logic exp_m;
    rstn     = 1'b0;
    ic_v     = 1'b0;
    dc_v     = 1'b0;
    ic_addr  = 64'h0000_0000_8000_0000;
    dc_addr  = 64'h0000_0000_9000_0010;
    dc_read  = 1'b0;
    dc_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    dc_wmask = 8'hF0;
    m_rdy    = 1'b1;
    m_rsp_v  = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    #3;
    chk("rst_i_rsp", 64'(ic_rsp_v), 64'd0);
    chk("rst_d_rsp", 64'(dc_rsp_v), 64'd0);
    chk("rst_rsp_rdy", 64'(m_rsp_rdy), 64'd1);
    chk("rst_cmd_vld", 64'(m_v), 64'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Single I-cache read
    issue(1'b1, 1'b0, ID_ICACHE, 64'h1122_3344_5566_7788, 1'b0);
    ic_v = 1'b0;
    chk("ic_wdata0", m_wdata, 64'd0);
    do_rsp(64'h0);

    // Both masters contending, memory always ready
    for (int i = 0; i < 4; i++) begin
`ifdef BIU_RR_ARB_EN
      exp_m = (i % 2 == 0) ? ID_DCACHE : ID_ICACHE;
`else
      exp_m = ID_DCACHE;
`endif
      issue(1'b1, 1'b1, exp_m, 64'h100 + 64'(i), 1'b0);
    end
    ic_v = 1'b0;
    dc_v = 1'b0;
    repeat (4) do_rsp(64'h0);

    // Grant lock: I-cache stalled by memory, D-cache shows up mid-stall
    m_rdy = 1'b0;
    ic_v  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dc_v = (c >= 1);
      #2;
      chk("lock_vld", 64'(m_v), 64'd1);
      chk("lock_addr", m_addr, ic_addr);
      chk("lock_read", 64'(m_read), 64'd1);
      chk("lock_i_rdy", 64'(ic_rdy), 64'd0);
      chk("lock_d_rdy", 64'(dc_rdy), 64'd0);
      tick();
    end
    m_rdy = 1'b1;
    issue(1'b1, 1'b1, ID_ICACHE, 64'hAAAA_0001, 1'b0);
    issue(1'b0, 1'b1, ID_DCACHE, 64'hAAAA_0002, 1'b0);
    dc_v = 1'b0;
    repeat (2) do_rsp(64'h0);

    // FIFO full, then a pop in the same cycle must still block the command
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, ID_ICACHE, 64'h200 + 64'(i), 1'b0);
    ic_v = 1'b1;
    rsp_drive(64'h0);
    #2;
    chk("full_i_rdy", 64'(ic_rdy), 64'd0);
    chk("full_cmd_vld", 64'(m_v), 64'd0);
    rsp_check();
    tick();
    m_rsp_v = 1'b0;
    issue(1'b1, 1'b0, ID_ICACHE, 64'h204, 1'b0);
    ic_v = 1'b0;
    repeat (4) do_rsp(64'h0);

    // Ordered routing with an error response in the middle
    issue(1'b1, 1'b0, ID_ICACHE, 64'hA, 1'b0);
    issue(1'b0, 1'b1, ID_DCACHE, 64'hB, 1'b1);
    issue(1'b1, 1'b0, ID_ICACHE, 64'hC, 1'b0);
    ic_v = 1'b0;
    dc_v = 1'b0;
    repeat (3) do_rsp(64'h0);

    // Reset with two transactions outstanding
    issue(1'b1, 1'b0, ID_ICACHE, 64'h300, 1'b0);
    issue(1'b0, 1'b1, ID_DCACHE, 64'h301, 1'b0);
    ic_v = 1'b0;
    dc_v = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_mid_cmd_vld", 64'(m_v), 64'd0);
    rstn = 1'b1;
    exp_q.delete();
    do_rsp(64'h5555_5555);
    // A stale count would block before four fresh commands are accepted.
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, ID_ICACHE, 64'h400 + 64'(i), 1'b0);
    ic_v = 1'b0;
    repeat (4) do_rsp(64'h0);
    do_rsp(64'h6666_6666);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
